// File: rtl/register_file_sb_if.sv
// register_file_sb_if
//   Bundles the read ports, write-back port, reservation/flush controls and
//   scoreboard outputs of register_file_sb.
//   Ports (packed per-port vectors, port i at [i*W +: W]):
//     rd_addr  NUM_RD*ADDR_W  read indices           (master -> slave)
//     rd_data  NUM_RD*DATA_W  read data              (slave  -> master)
//     rd_busy  NUM_RD         per-port busy flag     (slave  -> master)
//     wb_en/wb_addr/wb_data   write-back port        (master -> slave)
//     rsv_en/rsv_addr         destination reserve    (master -> slave)
//     flush                   clear all busy bits    (master -> slave)
//     busy_vec 2**ADDR_W      scoreboard             (slave  -> master)
//     busy_cnt ADDR_W+1       popcount of busy_vec   (slave  -> master)
interface register_file_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     flush;
  logic [(2**ADDR_W)-1:0]   busy_vec;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output rd_addr, wb_en, wb_addr, wb_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_vec, busy_cnt
  );

  modport slave (
    input  rd_addr, wb_en, wb_addr, wb_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_vec, busy_cnt
  );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb
//   Register file with NUM_RD combinational read ports, one write-back port
//   and a per-register busy scoreboard (reserve at decode, clear at
//   write-back, flush clears all).
//   Ports:
//     clk  - clock, all state updates on posedge
//     rst  - asynchronous reset, active-low
//     bus  - register_file_sb_if.slave (read, write-back, reserve, flush,
//            busy_vec, busy_cnt)
//   Optional feature: define WRITE_BYPASS_EN to forward a same-cycle
//   write-back to matching read ports (data and busy flag).
module register_file_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NUM_RD = 2
) (
  input  logic               clk,
  input  logic               rst,
  register_file_sb_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  // Register array; write is independent of flush/reserve.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (bus.wb_en) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Scoreboard next state: flush > reserve > write-back > hold.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (bus.flush)
        busy_d[r] = 1'b0;
      else if (bus.rsv_en && bus.rsv_addr == ADDR_W'(r))
        busy_d[r] = 1'b1;
      else if (bus.wb_en && bus.wb_addr == ADDR_W'(r))
        busy_d[r] = 1'b0;
    end
  end

  // Count is computed from the next vector so the registered count always
  // matches the registered vector.
  always_comb begin
    cnt_d = '0;
    for (int unsigned r = 0; r < DEPTH; r++)
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[r]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.busy_vec = busy_q;
  assign bus.busy_cnt = cnt_q;

  // Read ports.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i*DATA_W +: DATA_W] = regs[bus.rd_addr[i*ADDR_W +: ADDR_W]];
      bus.rd_busy[i]                  = busy_q[bus.rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef WRITE_BYPASS_EN
      // A same-cycle write-back resolves the hazard unless a new producer
      // reserves the same register in that cycle.
      if (bus.wb_en && bus.wb_addr == bus.rd_addr[i*ADDR_W +: ADDR_W]) begin
        bus.rd_data[i*DATA_W +: DATA_W] = bus.wb_data;
        bus.rd_busy[i] = !bus.flush && bus.rsv_en &&
                         (bus.rsv_addr == bus.rd_addr[i*ADDR_W +: ADDR_W]);
      end
`endif
    end
  end

endmodule
